// File: rtl/hsv_colour_tracker_if.sv
// Avalon-ST style video stream bundle used for both the sink and source
// sides of hsv_colour_tracker: 24-bit data plus valid/sop/eop/ready.
interface hsv_colour_tracker_if;
  logic [23:0] data;
  logic        valid;
  logic        sop;
  logic        eop;
  logic        ready;

  modport master (output data, output valid, output sop, output eop, input ready);
  modport slave  (input data, input valid, input sop, input eop, output ready);
endinterface

// File: rtl/hsv_colour_tracker.sv
// HSV threshold-window classifier: emits a binary mask stream and a per-frame bounding box.
// Optional feature: define BBOX_OVERLAY_EN to draw the previous frame's box border in red.
module hsv_colour_tracker #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480
) (
  input  logic                        clk,
  input  logic                        reset_n,
  hsv_colour_tracker_if.slave         sink,
  hsv_colour_tracker_if.master        source,
  input  logic [7:0]                  h_min,
  input  logic [7:0]                  h_max,
  input  logic [7:0]                  s_min,
  input  logic [7:0]                  s_max,
  input  logic [7:0]                  v_min,
  input  logic [7:0]                  v_max,
  output logic [10:0]                 bbox_x_min,
  output logic [10:0]                 bbox_x_max,
  output logic [10:0]                 bbox_y_min,
  output logic [10:0]                 bbox_y_max,
  output logic [19:0]                 match_count,
  output logic                        bbox_found,
  output logic                        bbox_valid
);

  localparam logic [10:0] X_LAST    = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_LAST    = 11'(IMAGE_H - 1);
  localparam logic [19:0] COUNT_MAX = 20'hFFFFF;
  localparam logic [23:0] MASK_ON   = 24'hFFFFFF;
  localparam logic [23:0] MASK_OFF  = 24'h000000;

  typedef struct packed {
    logic [7:0] h_min;
    logic [7:0] h_max;
    logic [7:0] s_min;
    logic [7:0] s_max;
    logic [7:0] v_min;
    logic [7:0] v_max;
  } thresh_t;

  typedef struct packed {
    logic [10:0] x_min;
    logic [10:0] x_max;
    logic [10:0] y_min;
    logic [10:0] y_max;
    logic [19:0] count;
  } box_t;

  typedef enum logic {
    ST_IDLE,
    ST_FRAME
  } frame_state_t;

  localparam box_t ACC_CLEAR = '{x_min: 11'h7FF, x_max: 11'h000,
                                 y_min: 11'h7FF, y_max: 11'h000, count: 20'h00000};

  frame_state_t state_q, state_d;
  thresh_t      th_in, th_q, th_d;
  box_t         acc_q, acc_d;
  box_t         bbox_q;
  logic [10:0]  x_q, x_d, y_q, y_d;
  logic [23:0]  src_data_q;
  logic         src_valid_q, src_sop_q, src_eop_q;
  logic         bbox_found_q, bbox_valid_q;

  logic         sink_ready, accept, complete;
  logic [7:0]   hue, sat, val;
  logic         hue_ok, sat_ok, val_ok, match;
  logic [23:0]  pixel_out;

  assign th_in = '{h_min: h_min, h_max: h_max, s_min: s_min,
                   s_max: s_max, v_min: v_min, v_max: v_max};

  // The output register can take a new beat whenever it is empty or draining.
  assign sink_ready = source.ready | ~src_valid_q;
  assign sink.ready = sink_ready;
  assign accept     = sink.valid & sink_ready;

  assign {hue, sat, val} = sink.data;

  // A window with h_min > h_max wraps through hue 0.
  assign hue_ok = (th_q.h_min <= th_q.h_max)
                ? ((hue >= th_q.h_min) && (hue <= th_q.h_max))
                : ((hue >= th_q.h_min) || (hue <= th_q.h_max));
  assign sat_ok = (sat >= th_q.s_min) && (sat <= th_q.s_max);
  assign val_ok = (val >= th_q.v_min) && (val <= th_q.v_max);
  assign match  = hue_ok & sat_ok & val_ok;

`ifdef BBOX_OVERLAY_EN
  logic in_x, in_y, on_col, on_row, on_border;

  // Border test uses the box of the previous completed frame.
  assign in_x      = (x_q >= bbox_q.x_min) && (x_q <= bbox_q.x_max);
  assign in_y      = (y_q >= bbox_q.y_min) && (y_q <= bbox_q.y_max);
  assign on_col    = (x_q == bbox_q.x_min) || (x_q == bbox_q.x_max);
  assign on_row    = (y_q == bbox_q.y_min) || (y_q == bbox_q.y_max);
  assign on_border = bbox_found_q && ((on_col && in_y) || (on_row && in_x));
  assign pixel_out = on_border ? 24'hFF0000 : (match ? MASK_ON : MASK_OFF);
`else
  assign pixel_out = match ? MASK_ON : MASK_OFF;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    th_d     = th_q;
    acc_d    = acc_q;
    x_d      = x_q;
    y_d      = y_q;
    complete = 1'b0;

    if (accept) begin
      if (sink.sop) begin
        th_d    = th_in;
        acc_d   = ACC_CLEAR;
        x_d     = '0;
        y_d     = '0;
        state_d = sink.eop ? ST_IDLE : ST_FRAME;
      end else begin
        if (match) begin
          if (x_q < acc_q.x_min) acc_d.x_min = x_q;
          if (x_q > acc_q.x_max) acc_d.x_max = x_q;
          if (y_q < acc_q.y_min) acc_d.y_min = y_q;
          if (y_q > acc_q.y_max) acc_d.y_max = y_q;
          if (acc_q.count != COUNT_MAX) acc_d.count = acc_q.count + 20'd1;
        end

        // Rows past the last one are folded onto the last row.
        if (x_q >= X_LAST) begin
          x_d = '0;
          if (y_q < Y_LAST) y_d = y_q + 11'd1;
        end else begin
          x_d = x_q + 11'd1;
        end

        // Only a frame opened by a sop may report; stray eops just close the packet.
        if (sink.eop) begin
          complete = (state_q == ST_FRAME);
          state_d  = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values,
    // independent of statement order.
    if (!reset_n) begin
      th_q         <= '0;
      acc_q        <= ACC_CLEAR;
      x_q          <= '0;
      y_q          <= '0;
      src_data_q   <= '0;
      src_valid_q  <= 1'b0;
      src_sop_q    <= 1'b0;
      src_eop_q    <= 1'b0;
      bbox_q       <= '0;
      bbox_found_q <= 1'b0;
      bbox_valid_q <= 1'b0;
    end else begin
      th_q         <= th_d;
      acc_q        <= acc_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bbox_valid_q <= complete;

      if (sink_ready) begin
        src_valid_q <= sink.valid;
        src_sop_q   <= sink.valid & sink.sop;
        src_eop_q   <= sink.valid & sink.eop;
        src_data_q  <= sink.sop ? sink.data : pixel_out;
      end

      if (complete) begin
        bbox_found_q <= (acc_d.count != '0);
        bbox_q       <= (acc_d.count != '0) ? acc_d : '0;
      end
    end
  end

  assign source.data  = src_data_q;
  assign source.valid = src_valid_q;
  assign source.sop   = src_sop_q;
  assign source.eop   = src_eop_q;

  assign bbox_x_min  = bbox_q.x_min;
  assign bbox_x_max  = bbox_q.x_max;
  assign bbox_y_min  = bbox_q.y_min;
  assign bbox_y_max  = bbox_q.y_max;
  assign match_count = bbox_q.count;
  assign bbox_found  = bbox_found_q;
  assign bbox_valid  = bbox_valid_q;

endmodule

// File: doc/hsv_colour_tracker.md
# hsv_colour_tracker

Downstream neighbour of the RGB-to-HSV stage. Consumes the 24-bit {hue, saturation, value} Avalon-ST video stream and classifies each pixel against a per-frame HSV threshold window. Emits a binary mask stream and, at end of frame, the bounding box and pixel count of all matching pixels. The result feeds the ball/target-detection readout.

## Interface
- IMAGE_W, 640, pixels per line (x counter wrap point)
- IMAGE_H, 480, lines per frame (y counter saturation point)
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- sink_data  in  24  {hue[23:16], sat[15:8], val[7:0]}; hue range 0..179
- sink_valid / sink_sop / sink_eop  in  1 each  Avalon-ST sink qualifiers
- sink_ready  out  1  sink backpressure
- source_data  out  24  mask pixel (or header word)
- source_valid / source_sop / source_eop  out  1 each  Avalon-ST source qualifiers
- source_ready  in  1  downstream backpressure
- h_min, h_max, s_min, s_max, v_min, v_max  in  8 each  threshold window, inclusive
- bbox_x_min, bbox_x_max  out  11  bounding-box columns of last completed frame
- bbox_y_min, bbox_y_max  out  11  bounding-box rows of last completed frame
- match_count  out  20  matching pixels in last completed frame
- bbox_found  out  1  last completed frame had ≥1 match
- bbox_valid  out  1  one-cycle pulse when the bbox_* / match_count outputs update

## Operation
- Beat accepted when sink_valid & sink_ready.
- sop beat is a header:
  - data passes through unchanged;
  - x, y, accumulators and match count are cleared;
  - all six thresholds are latched into shadow registers.
- Every non-sop beat is a pixel, the eop beat included.
- Match when all three hold:
  - s_min ≤ sat ≤ s_max;
  - v_min ≤ val ≤ v_max;
  - hue in range. If h_min ≤ h_max: h_min ≤ hue ≤ h_max. If h_min > h_max, the range wraps: hue ≥ h_min or hue ≤ h_max.
- Pixel output: 24'hFFFFFF on match, 24'h000000 otherwise.
- Position counters:
  - x increments per pixel; at IMAGE_W-1 it wraps to 0 and y increments.
  - y saturates at IMAGE_H-1. Extra pixels are still classified and counted at row IMAGE_H-1.
- On match:
  - x_min/x_max/y_min/y_max update with unsigned min/max;
  - match count increments, saturating at 20'hFFFFF.
  - Accumulator clear values: min = 11'h7FF, max = 0.
- Frame completion on an accepted eop pixel beat, using the values including that beat:
  - bbox_* and match_count are loaded from the accumulators;
  - bbox_found = (count≠0); if count = 0, all bbox_* outputs = 0;
  - bbox_valid pulses.
- sop & eop on the same beat is a header-only packet: passthrough, no completion.
- A sop arriving before eop discards the partial frame; no bbox_valid is issued.
- Threshold inputs changing mid-frame have no effect until the next sop.

## Timing
- One-stage registered pipeline; source_* lags the accepted sink beat by one cycle.
- sink_ready = source_ready | ~source_valid (combinational). The output register loads whenever sink_ready is high.
- While stalled (source_valid & ~source_ready), the output register and all counters hold.
- bbox_* / match_count / bbox_found update, and bbox_valid asserts, in the same cycle the eop beat appears on source_* as source_valid. bbox_valid is high for exactly one cycle regardless of source_ready.
- Reset values (next edge with reset_n low):
  - source_valid, source_sop, source_eop, source_data = 0;
  - bbox_* = 0, match_count = 0, bbox_found = 0, bbox_valid = 0;
  - x = y = 0; accumulators cleared; shadow thresholds = 0.
- Reset mid-frame drops the in-flight beat. Pixels arriving before the next sop are classified but never produce bbox_valid.

## Configuration
- BBOX_OVERLAY_EN defined:
  - a pixel whose (x, y) lies on the border of the previous completed frame's box is output as 24'hFF0000, overriding the mask value;
  - the border is x ∈ {bbox_x_min, bbox_x_max} with y in [bbox_y_min, bbox_y_max], or y ∈ {bbox_y_min, bbox_y_max} with x in [bbox_x_min, bbox_x_max];
  - the overlay is drawn only if bbox_found = 1.
- Undefined: pure binary mask output; the block is otherwise identical.

## Test plan
- 4×2 frame (IMAGE_W=4, IMAGE_H=2), window H 10..20 / S 50..255 / V 50..255, matches at (1,0) and (2,1) → mask FFFFFF at those beats only; bbox x 1..2, y 0..1, count 2, bbox_found=1, one bbox_valid pulse.
- Wrap-around hue window h_min=170, h_max=5: hues 175, 3, 90 → match, match, no-match.
- Frame with no matching pixels → bbox_found=0, all bbox_*=0, count 0, bbox_valid pulses once.
- source_ready held low for 5 cycles mid-frame → sink_ready low, source_data stable, counters frozen, final bbox identical to unstalled run.
- sop, 3 pixels, then a second sop before any eop, then a full frame → exactly one bbox_valid, reflecting only the second frame.
- BBOX_OVERLAY_EN defined: frame 1 yields box x 1..2, y 0..1 → in frame 2, pixels on that border output FF0000; reset asserted mid-frame 2 → all outputs zero the next cycle.
